// File: rtl/game_event_ctrl_pkg.sv
// Shared definitions for the game event controller: FSM encodings,
// frame-end scan position and event bus bit positions.
package game_event_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SERVE     = 2'd1;
  localparam logic [1:0] ST_PLAY      = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  localparam logic [9:0] FRAME_END_X = 10'd639;
  localparam logic [9:0] FRAME_END_Y = 10'd479;

  localparam int EV_SCORE   = 0;
  localparam int EV_LIVES   = 1;
  localparam int EV_OVER    = 2;
  localparam int EV_RESTART = 3;

  function automatic logic is_frame_end(input logic pix_en, input logic [9:0] x,
                                        input logic [9:0] y);
    return pix_en && (x == FRAME_END_X) && (y == FRAME_END_Y);
  endfunction

endpackage

// File: rtl/game_event_ctrl_stretcher.sv
// Registered fixed-width pulse generator; triggers arriving while the
// pulse is still running are dropped so downstream sees a single clean edge.
module event_pulse_stretcher #(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic pulse
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 4'd0;
      pulse <= 1'b0;
    end else if (cnt == 4'd0) begin
      if (trigger) begin
        cnt   <= 4'(PULSE_LEN);
        pulse <= 1'b1;
      end
    end else begin
      cnt   <= cnt - 4'd1;
      pulse <= (cnt > 4'd1);
    end
  end

endmodule

// File: rtl/game_event_ctrl.sv
// Game event controller: tracks per-frame ball collisions, runs the
// serve/play/game-over flow and drives stretched event pulses to the OSD.
module game_event_ctrl
  import game_event_ctrl_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int PULSE_LEN    = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       ball_pix,
  input  logic       paddle_pix,
  input  logic       floor_pix,
  input  logic       start_btn,
  output logic [7:0] events,
  output logic       ball_enable,
  output logic [2:0] lives
);

  logic       sync0, sync1, sync_d;
  logic       start_evt, frame_end;
  logic [1:0] state, state_nx;
  logic [5:0] frame_cnt, frame_cnt_nx;
  logic [2:0] lives_nx;
  logic       hit_flag, miss_flag, hit_now, miss_now;
  logic       trig_score, trig_lives, trig_restart;
  logic       score_pulse, lives_pulse, restart_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync0  <= start_btn;
      sync1  <= sync0;
      sync_d <= sync1;
    end
  end

  assign start_evt = sync1 & ~sync_d;
  assign frame_end = is_frame_end(pix_en, vga_x, vga_y);

  // Collisions on the frame_end pixel itself still belong to this frame.
  assign hit_now  = hit_flag  | ((state == ST_PLAY) & pix_en & ball_pix & paddle_pix);
  assign miss_now = miss_flag | ((state == ST_PLAY) & pix_en & ball_pix & floor_pix);

  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      hit_flag  <= 1'b0;
      miss_flag <= 1'b0;
    end else begin
      hit_flag  <= hit_now;
      miss_flag <= miss_now;
    end
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    lives_nx     = lives;
    trig_score   = 1'b0;
    trig_lives   = 1'b0;
    trig_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        lives_nx = 3'(LIVES_INIT);
        if (start_evt) begin
          state_nx     = ST_SERVE;
          frame_cnt_nx = 6'd0;
        end
      end
      ST_SERVE: begin
        if (frame_end) begin
          if (frame_cnt == 6'(SERVE_FRAMES - 1)) state_nx = ST_PLAY;
          else frame_cnt_nx = frame_cnt + 6'd1;
        end
      end
      ST_PLAY: begin
        if (frame_end && miss_now) begin
          trig_lives = 1'b1;
          lives_nx   = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
          if (lives <= 3'd1) begin
            state_nx = ST_GAME_OVER;
          end else begin
            state_nx     = ST_SERVE;
            frame_cnt_nx = 6'd0;
          end
        end else if (frame_end && hit_now) begin
          trig_score = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (start_evt) begin
          state_nx     = ST_IDLE;
          trig_restart = 1'b1;
          lives_nx     = 3'(LIVES_INIT);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame_cnt <= 6'd0;
      lives     <= 3'(LIVES_INIT);
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      lives     <= lives_nx;
    end
  end

  event_pulse_stretcher #(.PULSE_LEN(PULSE_LEN)) u_score (
    .clk(clk), .reset(reset), .trigger(trig_score), .pulse(score_pulse));
  event_pulse_stretcher #(.PULSE_LEN(PULSE_LEN)) u_lives (
    .clk(clk), .reset(reset), .trigger(trig_lives), .pulse(lives_pulse));
  event_pulse_stretcher #(.PULSE_LEN(PULSE_LEN)) u_restart (
    .clk(clk), .reset(reset), .trigger(trig_restart), .pulse(restart_pulse));

  always_comb begin
    events             = 8'h00;
    events[EV_SCORE]   = score_pulse;
    events[EV_LIVES]   = lives_pulse;
    events[EV_OVER]    = (state == ST_GAME_OVER);
    events[EV_RESTART] = restart_pulse;
  end

  assign ball_enable = (state == ST_PLAY);

endmodule
